// File: rtl/mem_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_stage_pkg
//   Shared definitions for the MEM stage: access size codes, FSM state codes
//   and the small helpers that derive byte enables, store lanes and
//   alignment faults from an access size and the low address bits.
// ---------------------------------------------------------------------------
package mem_access_stage_pkg;

    // Access size codes as carried on mem_size_i. Code 2'b11 is not named
    // and falls through to word handling everywhere.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Halves must sit on an even byte, words on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    // Little-endian lane enables for the addressed bytes.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated into every lane; the byte enables pick the
    // lane that actually gets written, so no shifting is needed.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{sd[7:0]}};
            SZ_HALF: wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
//   Data-memory request/acknowledge bus between the MEM stage (master) and
//   the data memory or its bus adapter (slave).
//   dmem_req_o    request, held until dmem_ack_i
//   dmem_we_o     1 = write
//   dmem_addr_o   word-aligned byte address
//   dmem_be_o     byte enables, little-endian lanes
//   dmem_wdata_o  store data replicated into the addressed lanes
//   dmem_ack_i    access complete, dmem_rdata_i valid in the same cycle
//   dmem_rdata_i  read word
//   The _o/_i suffixes are from the master's point of view.
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align
//   Combinational load formatter: selects the addressed byte or halfword of
//   the read word and sign- or zero-extends it to 32 bits.
//   rdata_i     read word from data memory
//   offset_i    byte offset of the access (addr[1:0])
//   size_i      access size code (2'b11 behaves as word)
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   result_o    value for MEM/WB Write_Data_in
// ---------------------------------------------------------------------------
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lane[offset_i];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM stage of the pipelined MIPS core. Converts EX/MEM load/store
//   controls into one req/ack data-memory transaction, formats load data for
//   MEM/WB, stalls the upstream stages until the access finishes, and traps
//   misaligned accesses and bus timeouts.
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   ex_valid_i      EX/MEM holds a real instruction
//   mem_read_i      load
//   mem_write_i     store (wins when both read and write are set)
//   mem_size_i      00 byte, 01 half, 10/11 word
//   mem_unsigned_i  zero-extend loads
//   addr_i          effective address
//   store_data_i    right-justified store value
//   dmem            data-memory bus, master side
//   load_data_o     aligned/extended load result (0 for stores and errors)
//   stall_o         hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble
//   misalign_o      one-cycle pulse: misaligned access, no bus cycle issued
//   bus_err_o       one-cycle pulse: no ack within TIMEOUT cycles
// ---------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [1:0]           mem_size_i,
    input  logic                 mem_unsigned_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          store_data_i,
    mem_access_stage_if.master   dmem,
    output logic [31:0]          load_data_o,
    output logic                 stall_o,
    output logic                 misalign_o,
    output logic                 bus_err_o
);

    // Counter value of the last BUSY cycle; the request is therefore held
    // for exactly TIMEOUT cycles before a bus error is raised.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        load_data_q, load_data_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q, bus_err_d;
    // Load formatting controls captured at accept so the result does not
    // depend on EX/MEM staying put while the bus is busy.
    logic               is_load_q, is_load_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic               uns_q, uns_d;

    logic               access;
    logic               misaligned;
    logic [31:0]        aligned_data;

    assign access     = ex_valid_i & (mem_read_i | mem_write_i);
    assign misaligned = is_misaligned(mem_size_i, addr_i[1:0]);

    mem_load_align u_load_align (
        .rdata_i    (dmem.dmem_rdata_i),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (aligned_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        is_load_d   = is_load_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        stall_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // Stall in the accept cycle even for a trapped access so
                    // the faulting instruction is still in EX/MEM during DONE.
                    stall_o = 1'b1;
                    if (misaligned) begin
                        misalign_d  = 1'b1;
                        load_data_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        req_d     = 1'b1;
                        we_d      = mem_write_i;
                        addr_d    = {addr_i[31:2], 2'b00};
                        be_d      = byte_enables(mem_size_i, addr_i[1:0]);
                        wdata_d   = store_lanes(mem_size_i, store_data_i);
                        is_load_d = ~mem_write_i;
                        size_d    = mem_size_i;
                        off_d     = addr_i[1:0];
                        uns_d     = mem_unsigned_i;
                        cnt_d     = '0;
                        state_d   = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                stall_o = 1'b1;
                // Ack is tested first so an ack on the final counter value
                // completes normally instead of raising a bus error.
                if (dmem.dmem_ack_i) begin
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    load_data_d = is_load_q ? aligned_data : 32'h0;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    load_data_d = '0;
                    bus_err_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Single release cycle: the same instruction is still on the
            // inputs, so nothing may be accepted here.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            is_load_q   <= 1'b0;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            is_load_q   <= is_load_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
        end
    end

    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign load_data_o       = load_data_q;
    assign misalign_o        = misalign_q;
    assign bus_err_o         = bus_err_q;

endmodule
